qspi_flash_read_engine: RTL

- Upstream sequencer for the QSPI host-mode transceiver.
- Runs complete quad-output fast-read transactions against a serial NOR flash: chip select, opcode, address, dummy byte, then N quad-lane data bytes.
- Drives the transceiver's byte-level shift controls and owns chip select, which the transceiver does not manage.
- Delivers read bytes as a valid-only stream to the fabric (no backpressure).

---
 rtl/qspi_flash_read_engine_if.sv | 22 ++
 rtl/qspi_flash_read_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_read_engine_if.sv
// Fabric-side request/read-stream bundle for qspi_flash_read_engine.
// The fabric drives through the master modport; the engine uses the slave modport.
interface qspi_flash_read_engine_if;
  logic        req;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        busy;
  logic        done;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;

  modport master (
    output req, req_addr, req_len,
    input  busy, done, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req, req_addr, req_len,
    output busy, done, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/qspi_flash_read_engine.sv
// Quad-output fast-read sequencer: CS, opcode, address, dummy, then N quad data bytes.
// Optional macro QSPI_FLASH_4BYTE_ADDR_EN selects opcode 8'h6C with a 4-byte address.
module qspi_flash_read_engine #(
  parameter int unsigned CS_SETUP_CYCLES = 4,
  parameter int unsigned CS_HOLD_CYCLES  = 4,
  parameter logic [7:0]  READ_OPCODE     = 8'h6B
) (
  input  logic                      clk,
  input  logic                      rst_n,
  qspi_flash_read_engine_if.slave   host,
  output logic                      qspi_cs_n_o,
  output logic                      shift_en_o,
  output logic                      quad_shift_en_o,
  output logic                      auto_restart_o,
  output logic [7:0]                tx_data_o,
  input  logic                      shift_done_i,
  input  logic [7:0]                rx_data_i
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_OPCODE   = 3'd2;
  localparam logic [2:0] ST_ADDR     = 3'd3;
  localparam logic [2:0] ST_DUMMY    = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;
  localparam logic [2:0] ST_CS_HOLD  = 3'd6;
  localparam logic [2:0] ST_CS_HIGH  = 3'd7;

  localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES
                                                                        : CS_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CYCLES - 1);

  logic [7:0]  opcode_byte;
  logic [1:0]  last_addr_idx;
  logic [31:0] addr_load;

`ifdef QSPI_FLASH_4BYTE_ADDR_EN
  assign opcode_byte   = 8'h6C;
  assign last_addr_idx = 2'd3;
  assign addr_load     = host.req_addr;
`else
  logic unused_addr_hi;
  assign opcode_byte    = READ_OPCODE;
  assign last_addr_idx  = 2'd2;
  // Left-align the 3-byte address so bits [31:24] always hold the next byte to send.
  assign addr_load      = {host.req_addr[23:0], 8'h00};
  assign unused_addr_hi = ^host.req_addr[31:24];
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      rem_q, rem_d;
  logic [7:0]       tx_q, tx_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             shift_en_q, shift_en_d;
  logic             quad_q, quad_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_last_q, rd_last_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    tx_d       = tx_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    shift_en_d = 1'b0;
    quad_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_last_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.req) begin
          if (host.req_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = addr_load;
            len_d   = host.req_len;
            busy_d  = 1'b1;
            cs_n_d  = 1'b0;
            cnt_d   = SETUP_LOAD;
            state_d = ST_CS_SETUP;
          end
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == '0) begin
          shift_en_d = 1'b1;
          tx_d       = opcode_byte;
          state_d    = ST_OPCODE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OPCODE: begin
        if (shift_done_i) begin
          shift_en_d = 1'b1;
          tx_d       = addr_q[31:24];
          addr_d     = {addr_q[23:0], 8'h00};
          idx_d      = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (shift_done_i) begin
          shift_en_d = 1'b1;
          if (idx_q == last_addr_idx) begin
            tx_d    = 8'h00;
            state_d = ST_DUMMY;
          end else begin
            tx_d   = addr_q[31:24];
            addr_d = {addr_q[23:0], 8'h00};
            idx_d  = idx_q + 2'd1;
          end
        end
      end
      ST_DUMMY: begin
        if (shift_done_i) begin
          quad_d  = 1'b1;
          rem_d   = len_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shift_done_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rx_data_i;
          rd_last_d  = (rem_q == 16'd1);
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            cnt_d   = HOLD_LOAD;
            state_d = ST_CS_HOLD;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = ST_CS_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CS_HIGH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      tx_q       <= '0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      shift_en_q <= 1'b0;
      quad_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tx_q       <= tx_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      shift_en_q <= shift_en_d;
      quad_q     <= quad_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Low on the final byte so the transceiver stops chaining after it.
  assign auto_restart_o  = (state_q == ST_DATA) && (rem_q > 16'd1);
  assign qspi_cs_n_o     = cs_n_q;
  assign shift_en_o      = shift_en_q;
  assign quad_shift_en_o = quad_q;
  assign tx_data_o       = tx_q;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.rd_valid   = rd_valid_q;
  assign host.rd_data    = rd_data_q;
  assign host.rd_last    = rd_last_q;

endmodule
